// File: rtl/code_pkg.sv
// Shared types and constants for the code loader and its neighbours.
package code_pkg;

  localparam int unsigned LINE_W        = 32;
  localparam int unsigned CODE_SIZE     = 12;
  localparam int unsigned MAX_CODE_LINE = 100;
  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StWordHi,
    StWordLo,
    StCheck,
    StError
  } state_e;

endpackage

// File: rtl/code_loader_if.sv
// Host byte stream in, code_storage write port out.
interface code_loader_if
  import code_pkg::*;
#(
  parameter int unsigned CodeSize = CODE_SIZE
) ();

  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [LINE_W-1:0]   write_line;
  logic [CodeSize-1:0] write_data;
  logic                is_write;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  write_line,
    input  write_data,
    input  is_write
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output write_line,
    output write_data,
    output is_write
  );

endinterface

// File: rtl/loader_checksum.sv
// Clear/accumulate/compare XOR register over a byte stream.
module loader_checksum (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_accum,
  input  logic [7:0] i_data,
  output logic       o_match
);

  logic [7:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_sum <= 8'h00;
    end else if (i_clear) begin
      r_sum <= 8'h00;
    end else if (i_accum) begin
      r_sum <= r_sum ^ i_data;
    end
  end

  assign o_match = (i_data == r_sum);

endmodule

// File: rtl/code_loader.sv
// Frame receiver that assembles code words and writes them to code_storage.
// Optional inter-byte timeout enabled by defining CODE_LOADER_TIMEOUT_EN.
module code_loader
  import code_pkg::*;
#(
`ifdef CODE_LOADER_TIMEOUT_EN
  parameter int unsigned TimeoutCycles = 1000,
`endif
  parameter int unsigned CodeSize    = CODE_SIZE,
  parameter int unsigned MaxCodeLine = MAX_CODE_LINE
) (
  input  logic          i_clk,
  input  logic          i_reset,
  code_loader_if.slave  bus,
  output logic          o_active,
  output logic          o_busy,
  output logic          o_load_error
);

  state_e              r_state;
  logic [7:0]          r_len_hi;
  logic [15:0]         r_len;
  logic [15:0]         r_index;
  logic [7:0]          r_hi;
  logic [LINE_W-1:0]   r_write_line;
  logic [CodeSize-1:0] r_write_data;
  logic                r_is_write;
  logic                r_active;
  logic                r_load_error;

  logic        w_acc;
  logic        w_sync;
  logic        w_cs_accum;
  logic        w_cs_match;
  logic        w_timeout;
  logic [15:0] w_len;
  logic [15:0] w_word16;
  logic [15:0] w_index_nxt;

  assign bus.in_ready = i_reset;
  assign w_acc        = bus.in_valid && i_reset;
  assign w_sync       = w_acc && (bus.in_data == SYNC_BYTE) &&
                        (r_state == StIdle || r_state == StError);
  assign w_cs_accum   = w_acc && (r_state == StLenHi || r_state == StLenLo ||
                                  r_state == StWordHi || r_state == StWordLo);
  assign w_len        = {r_len_hi, bus.in_data};
  assign w_word16     = {r_hi, bus.in_data};
  assign w_index_nxt  = r_index + 16'd1;

  assign o_busy = (r_state == StLenHi) || (r_state == StLenLo) || (r_state == StWordHi) ||
                  (r_state == StWordLo) || (r_state == StCheck);

  loader_checksum u_checksum (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_sync),
    .i_accum (w_cs_accum),
    .i_data  (bus.in_data),
    .o_match (w_cs_match)
  );

`ifdef CODE_LOADER_TIMEOUT_EN
  logic [31:0] r_idle_cnt;

  // Counts only idle cycles inside a frame; any accept or leaving busy restarts it.
  always_ff @(posedge i_clk) begin
    if (!i_reset || !o_busy || w_acc) begin
      r_idle_cnt <= 32'd0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end

  assign w_timeout = o_busy && !w_acc && (r_idle_cnt == TimeoutCycles - 1);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_len_hi     <= 8'h00;
      r_len        <= 16'h0000;
      r_index      <= 16'h0000;
      r_hi         <= 8'h00;
      r_write_line <= '0;
      r_write_data <= '0;
      r_is_write   <= 1'b0;
      r_active     <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_is_write <= 1'b0;
      if (w_timeout) begin
        r_state      <= StError;
        r_load_error <= 1'b1;
      end else if (w_acc) begin
        unique case (r_state)
          StIdle, StError: begin
            if (bus.in_data == SYNC_BYTE) begin
              r_state      <= StLenHi;
              r_active     <= 1'b0;
              r_load_error <= 1'b0;
            end
          end
          StLenHi: begin
            r_len_hi <= bus.in_data;
            r_state  <= StLenLo;
          end
          StLenLo: begin
            if (w_len == 16'd0 || w_len > 16'(MaxCodeLine)) begin
              r_state      <= StError;
              r_load_error <= 1'b1;
            end else begin
              r_len   <= w_len;
              r_index <= 16'd0;
              r_state <= StWordHi;
            end
          end
          StWordHi: begin
            r_hi    <= bus.in_data;
            r_state <= StWordLo;
          end
          StWordLo: begin
            r_write_line <= LINE_W'(r_index);
            r_write_data <= w_word16[CodeSize-1:0];
            r_is_write   <= 1'b1;
            r_index      <= w_index_nxt;
            r_state      <= (w_index_nxt == r_len) ? StCheck : StWordHi;
          end
          StCheck: begin
            if (w_cs_match) begin
              r_state  <= StIdle;
              r_active <= 1'b1;
            end else begin
              r_state      <= StError;
              r_load_error <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.write_line = r_write_line;
  assign bus.write_data = r_write_data;
  assign bus.is_write   = r_is_write;
  assign o_active       = r_active;
  assign o_load_error   = r_load_error;

endmodule

// File: tb/tb_code_loader.sv
// Randomised frame bench for code_loader with a frame-level reference model.
module tb_code_loader;
  import code_pkg::*;

  localparam int unsigned CS = 12;

  logic clk = 1'b0;
  logic reset;
  logic active, busy, load_error;

  always #5 clk = ~clk;

  code_loader_if #(.CodeSize(CS)) bus ();

  code_loader #(
`ifdef CODE_LOADER_TIMEOUT_EN
    .TimeoutCycles (20),
`endif
    .CodeSize      (CS),
    .MaxCodeLine   (100)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .bus          (bus),
    .o_active     (active),
    .o_busy       (busy),
    .o_load_error (load_error)
  );

  int n_chk = 0;
  int n_bad = 0;
  bit prev_act = 1'b0;
  bit prev_err = 1'b0;

  logic [31:0] obs_line[$];
  logic [31:0] obs_data[$];

  always @(negedge clk) begin
    if (bus.is_write === 1'b1) begin
      obs_line.push_back(bus.write_line);
      obs_data.push_back(32'(bus.write_data));
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Reference: a frame is accepted iff 1<=N<=100; words are written in order with the
  // upper bits masked; active only if the checksum byte equals the XOR of all bytes after SYNC.
  task automatic run_frame(input string tag, input logic [15:0] n, input logic [15:0] w[$],
                           input bit bad, input int maxgap);
    logic [7:0] by[$];
    logic [7:0] chk;
    bit ok;
    bit exp_act;
    int nexp;
    ok = (n != 16'd0) && (n <= 16'd100);
    by.push_back(n[15:8]);
    by.push_back(n[7:0]);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        by.push_back(w[i][15:8]);
        by.push_back(w[i][7:0]);
      end
      chk = 8'h00;
      foreach (by[i]) chk ^= by[i];
      if (bad) chk ^= 8'(1 << $urandom_range(0, 7));
      by.push_back(chk);
    end
    obs_line.delete();
    obs_data.delete();
    send_byte(SYNC_BYTE, $urandom_range(0, maxgap));
    check_val({tag, "/sync_busy"}, 32'(busy), 32'd1);
    check_val({tag, "/sync_act"}, 32'(active), 32'd0);
    foreach (by[i]) send_byte(by[i], (i == by.size() - 1) ? 0 : $urandom_range(0, maxgap));
    exp_act = ok && !bad;
    check_val({tag, "/act_next"}, 32'(active), 32'(exp_act));
    repeat (2) @(negedge clk);
    nexp = ok ? int'(n) : 0;
    check_val({tag, "/nwr"}, 32'(obs_line.size()), 32'(nexp));
    if (obs_line.size() == nexp) begin
      for (int i = 0; i < nexp; i++) begin
        check_val({tag, "/line"}, obs_line[i], 32'(i));
        check_val({tag, "/data"}, obs_data[i], {20'd0, w[i][11:0]});
      end
    end
    check_val({tag, "/act"}, 32'(active), 32'(exp_act));
    check_val({tag, "/err"}, 32'(load_error), 32'(!exp_act));
    check_val({tag, "/busy"}, 32'(busy), 32'd0);
    prev_act = exp_act;
    prev_err = !exp_act;
  endtask

  initial begin
    logic [15:0] w[$];
    logic [15:0] n;
    logic [7:0]  nb;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_wr", 32'(bus.is_write), 32'd0);
    check_val("rst_act", 32'(active), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(load_error), 32'd0);
    check_val("rst_line", bus.write_line, 32'd0);
    check_val("rst_data", 32'(bus.write_data), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("ready", 32'(bus.in_ready), 32'd1);

    w = '{16'h0123, 16'h0456};
    run_frame("nominal", 16'd2, w, 1'b0, 0);
    run_frame("badchk", 16'd2, w, 1'b1, 0);
    run_frame("len0", 16'd0, w, 1'b0, 0);
    run_frame("len101", 16'd101, w, 1'b0, 0);
    run_frame("after_len", 16'd2, w, 1'b0, 0);
    w = '{16'hFABC};
    run_frame("mask_gap", 16'd1, w, 1'b0, 3);

    // Abort a frame after the first high byte.
    obs_line.delete();
    obs_data.delete();
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("mid_ready", 32'(bus.in_ready), 32'd0);
    check_val("mid_busy", 32'(busy), 32'd0);
    check_val("mid_line", bus.write_line, 32'd0);
    check_val("mid_data", 32'(bus.write_data), 32'd0);
    send_byte(8'h34, 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_nowr", 32'(obs_line.size()), 32'd0);
    prev_act = 1'b0;
    prev_err = 1'b0;
    w = '{16'h0777, 16'h0888, 16'h0999};
    run_frame("post_rst", 16'd3, w, 1'b0, 1);

    for (int t = 0; t < 20; t++) begin
      repeat ($urandom_range(0, 2)) begin
        do nb = 8'($urandom); while (nb == SYNC_BYTE);
        send_byte(nb, 0);
      end
      check_val("hold_act", 32'(active), 32'(prev_act));
      check_val("hold_err", 32'(load_error), 32'(prev_err));
      w.delete();
      if ($urandom_range(0, 7) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(101, 400));
      end else begin
        n = 16'($urandom_range(1, 6));
        for (int i = 0; i < int'(n); i++) begin
          w.push_back(($urandom_range(0, 4) == 0) ? {SYNC_BYTE, 8'($urandom)} : 16'($urandom));
        end
      end
      run_frame("rand", n, w, ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

`ifdef CODE_LOADER_TIMEOUT_EN
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    repeat (19) @(negedge clk);
    check_val("to_early", 32'(load_error), 32'd0);
    @(negedge clk);
    check_val("to_err", 32'(load_error), 32'd1);
    check_val("to_act", 32'(active), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
